// File: rtl/wb_commit_checker.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_checker
// Brief    : End-of-test checker on the writeback retire stream. It shadows one
//            architectural register, watches for the end PC, and runs a stall
//            watchdog. Pass/fail/timeout status is sticky until reset.
// Revision : 1.0 - initial release
// ============================================================================
module wb_commit_checker #(
  parameter logic [31:0] END_PC     = 32'h1c000024,
  parameter int unsigned CHECK_REG  = 5,
  parameter logic [31:0] EXPECT_VAL = 32'h0000005a,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_rf_wen,
  input  logic [4:0]  wb_rf_waddr,
  input  logic [31:0] wb_rf_wdata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] retire_cnt,
  output logic [31:0] shadow_val
);

  localparam logic [4:0]  C_CHECK_ADDR = 5'(CHECK_REG);
  localparam bit          C_CHECK_EN   = (CHECK_REG != 0);
  localparam logic [31:0] C_TMO_LAST   = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_PASS = 3'd2,
    S_FAIL = 3'd3,
    S_TMO  = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_done;
  logic        r_pass;
  logic        r_fail;
  logic        r_timeout;
  logic [31:0] r_retire_cnt;
  logic [31:0] r_shadow;
  logic [31:0] r_idle_cnt;

  logic        w_active;
  logic        w_hit;
  logic        w_end;
  logic        w_expire;
  logic [31:0] w_cmp_val;

  assign w_active  = (r_state == S_IDLE) || (r_state == S_RUN);
  assign w_hit     = wb_rf_wen && (wb_rf_waddr == C_CHECK_ADDR) && C_CHECK_EN;
  // A write to the checked register by the end-PC instruction itself is
  // compared directly, since the shadow only picks it up at this same edge.
  assign w_cmp_val = w_hit ? wb_rf_wdata : r_shadow;
  assign w_end     = wb_valid && (wb_pc == END_PC);
  assign w_expire  = !wb_valid && (r_idle_cnt >= C_TMO_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_timeout    <= 1'b0;
      r_retire_cnt <= 32'd0;
      r_shadow     <= 32'd0;
      r_idle_cnt   <= 32'd0;
    end else if (w_active) begin
      if (wb_valid) begin
        r_idle_cnt <= 32'd0;
        if (r_retire_cnt != 32'hffffffff) begin
          r_retire_cnt <= r_retire_cnt + 32'd1;
        end
        if (w_hit) begin
          r_shadow <= wb_rf_wdata;
        end
        if (w_end) begin
          r_done <= 1'b1;
          if (w_cmp_val == EXPECT_VAL) begin
            r_state <= S_PASS;
            r_pass  <= 1'b1;
          end else begin
            r_state <= S_FAIL;
            r_fail  <= 1'b1;
          end
        end else begin
          r_state <= S_RUN;
        end
      end else begin
        r_idle_cnt <= r_idle_cnt + 32'd1;
        if (w_expire) begin
          r_state   <= S_TMO;
          r_done    <= 1'b1;
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign done       = r_done;
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign timeout    = r_timeout;
  assign retire_cnt = r_retire_cnt;
  assign shadow_val = r_shadow;

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_commit_checker
// Brief    : Directed bench for wb_commit_checker with a cycle-level model,
//            two DUT instances (checked register 5 and checked register 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_commit_checker;

  localparam logic [31:0] C_END_PC  = 32'h1c000024;
  localparam logic [31:0] C_EXPECT  = 32'h0000005a;
  localparam int          C_TIMEOUT = 8;

  logic        clk;
  logic        resetn;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_rf_wen;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_rf_wdata;

  logic        done_w    [2];
  logic        pass_w    [2];
  logic        fail_w    [2];
  logic        timeout_w [2];
  logic [31:0] cnt_w     [2];
  logic [31:0] shadow_w  [2];

  int n_vec = 0;
  int n_err = 0;

  wb_commit_checker #(
    .END_PC(C_END_PC), .CHECK_REG(5), .EXPECT_VAL(C_EXPECT), .TIMEOUT(C_TIMEOUT)
  ) u_dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_rf_wen(wb_rf_wen), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
    .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]), .timeout(timeout_w[0]),
    .retire_cnt(cnt_w[0]), .shadow_val(shadow_w[0])
  );

  wb_commit_checker #(
    .END_PC(C_END_PC), .CHECK_REG(0), .EXPECT_VAL(C_EXPECT), .TIMEOUT(C_TIMEOUT)
  ) u_dut0 (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_rf_wen(wb_rf_wen), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
    .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]), .timeout(timeout_w[1]),
    .retire_cnt(cnt_w[1]), .shadow_val(shadow_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-instance architectural view of the checker.
  logic [31:0] m_shadow [2] = '{32'd0, 32'd0};
  logic [31:0] m_cnt    [2] = '{32'd0, 32'd0};
  int          m_idle   [2] = '{0, 0};
  bit          m_pass   [2] = '{1'b0, 1'b0};
  bit          m_fail   [2] = '{1'b0, 1'b0};
  bit          m_tmo    [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge resetn) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        m_shadow[k] = 32'd0; m_cnt[k] = 32'd0; m_idle[k] = 0;
        m_pass[k] = 1'b0; m_fail[k] = 1'b0; m_tmo[k] = 1'b0;
      end else if (!(m_pass[k] || m_fail[k] || m_tmo[k])) begin
        if (wb_valid) begin
          int  creg;
          bit  wr;
          logic [31:0] seen;
          creg = (k == 0) ? 5 : 0;
          wr   = wb_rf_wen && (int'(wb_rf_waddr) == creg) && (creg != 0);
          seen = wr ? wb_rf_wdata : m_shadow[k];
          if (m_cnt[k] != 32'hffffffff) m_cnt[k] = m_cnt[k] + 1;
          m_idle[k] = 0;
          if (wr) m_shadow[k] = wb_rf_wdata;
          if (wb_pc == C_END_PC) begin
            if (seen == C_EXPECT) m_pass[k] = 1'b1;
            else                  m_fail[k] = 1'b1;
          end
        end else begin
          m_idle[k] = m_idle[k] + 1;
          if (m_idle[k] >= C_TIMEOUT) m_tmo[k] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      cmp($sformatf("done[%0d]", k),    32'(done_w[k]),    32'(m_pass[k] | m_fail[k] | m_tmo[k]));
      cmp($sformatf("pass[%0d]", k),    32'(pass_w[k]),    32'(m_pass[k]));
      cmp($sformatf("fail[%0d]", k),    32'(fail_w[k]),    32'(m_fail[k]));
      cmp($sformatf("timeout[%0d]", k), 32'(timeout_w[k]), 32'(m_tmo[k]));
      cmp($sformatf("retire_cnt[%0d]", k), cnt_w[k],       m_cnt[k]);
      cmp($sformatf("shadow_val[%0d]", k), shadow_w[k],    m_shadow[k]);
    end
  end

  task automatic retire(input logic [31:0] pc, input logic wen,
                        input logic [4:0] addr, input logic [31:0] data);
    wb_valid = 1'b1; wb_pc = pc; wb_rf_wen = wen; wb_rf_waddr = addr; wb_rf_wdata = data;
    @(posedge clk); #1;
    wb_valid = 1'b0; wb_rf_wen = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic lit(input string tag, input logic d, input logic p, input logic f,
                     input logic t, input logic [31:0] c, input logic [31:0] s);
    cmp({tag, ".done"},       32'(done_w[0]),    32'(d));
    cmp({tag, ".pass"},       32'(pass_w[0]),    32'(p));
    cmp({tag, ".fail"},       32'(fail_w[0]),    32'(f));
    cmp({tag, ".timeout"},    32'(timeout_w[0]), 32'(t));
    cmp({tag, ".retire_cnt"}, cnt_w[0],          c);
    cmp({tag, ".shadow_val"}, shadow_w[0],       s);
  endtask

  initial begin
    wb_valid = 1'b0; wb_pc = 32'd0; wb_rf_wen = 1'b0; wb_rf_waddr = 5'd0; wb_rf_wdata = 32'd0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lit("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    resetn = 1'b1;

    // Pass via shadow; stray wen without valid and r0 writes are ignored.
    retire(32'h1c000000, 1'b1, 5'd3, 32'h7);
    retire(32'h1c000004, 1'b0, 5'd0, 32'h0);
    wb_rf_wen = 1'b1; wb_rf_waddr = 5'd5; wb_rf_wdata = 32'h99;
    @(posedge clk); #1;
    wb_rf_wen = 1'b0;
    retire(32'h1c000008, 1'b1, 5'd5, 32'h5a);
    retire(32'h1c00000c, 1'b1, 5'd0, 32'h33);
    retire(C_END_PC,     1'b0, 5'd0, 32'h0);
    lit("s1_pass", 1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 32'h5a);
    cmp("s1_r0.fail", 32'(fail_w[1]), 32'd1);
    cmp("s1_r0.shadow_val", shadow_w[1], 32'd0);
    retire(C_END_PC, 1'b1, 5'd5, 32'h11);
    idle(2);
    lit("s1_frozen", 1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 32'h5a);
    do_reset();

    // Last write mismatches.
    retire(32'h1c000000, 1'b1, 5'd5, 32'h5a);
    retire(32'h1c000004, 1'b1, 5'd5, 32'h5b);
    retire(C_END_PC,     1'b0, 5'd0, 32'h0);
    lit("s2_fail", 1'b1, 1'b0, 1'b1, 1'b0, 32'd3, 32'h5b);
    do_reset();

    // End-PC instruction itself supplies the expected value.
    retire(32'h1c000000, 1'b1, 5'd5, 32'h11);
    retire(C_END_PC,     1'b1, 5'd5, 32'h5a);
    lit("s3_bypass", 1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 32'h5a);
    do_reset();

    // Watchdog: retirement in the expiring cycle wins, then a real timeout.
    retire(32'h1c000000, 1'b0, 5'd0, 32'h0);
    retire(32'h1c000004, 1'b0, 5'd0, 32'h0);
    idle(7);
    lit("s4_idle7", 1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 32'd0);
    retire(32'h1c000008, 1'b0, 5'd0, 32'h0);
    idle(7);
    lit("s4_saved", 1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd0);
    idle(1);
    lit("s4_tmo", 1'b1, 1'b0, 1'b0, 1'b1, 32'd3, 32'd0);
    retire(C_END_PC, 1'b1, 5'd5, 32'h5a);
    lit("s4_frozen", 1'b1, 1'b0, 1'b0, 1'b1, 32'd3, 32'd0);

    // Asynchronous reset from a terminal state and mid-run.
    #2 resetn = 1'b0;
    #1 lit("s5_rst_term", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    retire(32'h1c000000, 1'b1, 5'd5, 32'h5a);
    retire(32'h1c000004, 1'b0, 5'd0, 32'h0);
    #2 resetn = 1'b0;
    #1 lit("s5_rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    retire(32'h1c000000, 1'b1, 5'd5, 32'h5a);
    retire(32'h1c000004, 1'b0, 5'd0, 32'h0);
    retire(C_END_PC,     1'b0, 5'd0, 32'h0);
    lit("s5_pass", 1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 32'h5a);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
